// File: rtl/sort_pkg.sv
// ---------------------------------------------------------------------------
// sort_pkg
// Shared definitions for the sequential 8-bit sorter:
//   DATA_W  - element width in bits
//   state_t - controller states LOAD / SORT / DRAIN
//   idx_w() - width of an index register for an N-element batch
// ---------------------------------------------------------------------------
package sort_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // $clog2(n), but never narrower than one bit so that N=2 still gets
    // a usable index register.
    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/comparator_8bit.sv
// ---------------------------------------------------------------------------
// comparator_8bit
// The single shared magnitude comparator of the sorter. It orders one pair
// of unsigned operands.
//   A, B     : operands (A is the lower buffer position)
//   Min, Max : ordered results; when A == B, Min = A and Max = B, so equal
//              operands are never exchanged and the sort stays stable.
// ---------------------------------------------------------------------------
module comparator_8bit
    import sort_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] Min,
    output logic [DATA_W-1:0] Max
);

    logic a_gt_b;

    // Strictly greater: equality counts as "already in order".
    assign a_gt_b = (A > B);
    assign Min    = a_gt_b ? B : A;
    assign Max    = a_gt_b ? A : B;

endmodule

// File: rtl/sort_seq_8bit.sv
// ---------------------------------------------------------------------------
// sort_seq_8bit
// Sequential bubble sorter for batches of N unsigned 8-bit elements.
// A batch is loaded over a valid/ready stream, sorted in place with one
// compare-swap per clock through a single shared comparator, then streamed
// out in ascending order.
//
// Parameters
//   N          - elements per batch (2..16)
// Ports
//   clk        - clock, all state changes on the rising edge
//   rst        - synchronous active-high reset
//   in_valid   - load stream: data offered
//   in_ready   - load stream: high only in LOAD
//   in_data    - load stream: element
//   out_valid  - output stream: high only in DRAIN
//   out_ready  - output stream: consumer accepts
//   out_data   - output stream: sorted element, 0 when out_valid is low
//   busy       - high while sorting
//   swap_cnt   - (only with SORT_STAT_EN defined) swaps performed by the
//                current or most recent sort
//
// Build option: define SORT_STAT_EN to add the swap_cnt port and counter.
//
// Timing: SORT always runs (N-1) passes of (N-1) compares, i.e. (N-1)^2
// cycles, independent of the data.
// ---------------------------------------------------------------------------
module sort_seq_8bit
    import sort_pkg::*;
#(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
`ifdef SORT_STAT_EN
    ,
    output logic [7:0]        swap_cnt
`endif
);

    localparam int            IW       = idx_w(N);
    localparam logic [IW-1:0] LAST     = IW'(N - 1);
    localparam logic [IW-1:0] LAST_POS = IW'(N - 2);

    // -----------------------------------------------------------------------
    // Control state
    // -----------------------------------------------------------------------
    state_t        state_reg,  state_next;
    logic [IW-1:0] wr_idx_reg, wr_idx_next;
    logic [IW-1:0] rd_idx_reg, rd_idx_next;
    logic [IW-1:0] pass_reg,   pass_next;
    logic [IW-1:0] pos_reg,    pos_next;

    logic          accept;      // element written into the buffer this cycle
    logic          sort_en;     // compare-swap result written this cycle
    logic [IW-1:0] pos_p1;

    // Element storage, packed so each element can be owned by its own
    // generate block without multiple drivers on one variable.
    logic [N-1:0][DATA_W-1:0] buf_q;

    logic [DATA_W-1:0] a_val, b_val, min_val, max_val;

    assign pos_p1 = pos_reg + 1'b1;
    assign a_val  = buf_q[pos_reg];
    assign b_val  = buf_q[pos_p1];

    comparator_8bit u_cmp (
        .A   (a_val),
        .B   (b_val),
        .Min (min_val),
        .Max (max_val)
    );

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= LOAD;
            wr_idx_reg <= '0;
            rd_idx_reg <= '0;
            pass_reg   <= '0;
            pos_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            wr_idx_reg <= wr_idx_next;
            rd_idx_reg <= rd_idx_next;
            pass_reg   <= pass_next;
            pos_reg    <= pos_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        wr_idx_next = wr_idx_reg;
        rd_idx_next = rd_idx_reg;
        pass_next   = pass_reg;
        pos_next    = pos_reg;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        accept      = 1'b0;
        sort_en     = 1'b0;

        case (state_reg)
            LOAD: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    if (wr_idx_reg == LAST) begin
                        state_next  = SORT;
                        wr_idx_next = '0;
                        pass_next   = '0;
                        pos_next    = '0;
                    end else begin
                        wr_idx_next = wr_idx_reg + 1'b1;
                    end
                end
            end

            SORT: begin
                busy    = 1'b1;
                sort_en = 1'b1;
                if (pos_reg == LAST_POS) begin
                    pos_next = '0;
                    if (pass_reg == LAST_POS) begin
                        // Final compare of the final pass.
                        state_next = DRAIN;
                        pass_next  = '0;
                        rd_idx_next = '0;
                    end else begin
                        pass_next = pass_reg + 1'b1;
                    end
                end else begin
                    pos_next = pos_p1;
                end
            end

            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (rd_idx_reg == LAST) begin
                        state_next  = LOAD;
                        rd_idx_next = '0;
                        wr_idx_next = '0;
                    end else begin
                        rd_idx_next = rd_idx_reg + 1'b1;
                    end
                end
            end

            default: begin
                state_next = LOAD;
            end
        endcase
    end

    assign out_data = out_valid ? buf_q[rd_idx_reg] : '0;

    // -----------------------------------------------------------------------
    // Element registers. Loading and sorting never overlap in time, so the
    // priority below only matters for clarity. Contents are deliberately not
    // reset: a batch is always fully rewritten before it is sorted.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_buf
            logic [DATA_W-1:0] elem_reg;

            always_ff @(posedge clk) begin
                if (accept && (wr_idx_reg == IW'(gi))) begin
                    elem_reg <= in_data;
                end else if (sort_en && (pos_reg == IW'(gi))) begin
                    elem_reg <= min_val;
                end else if (sort_en && (pos_p1 == IW'(gi))) begin
                    elem_reg <= max_val;
                end
            end

            assign buf_q[gi] = elem_reg;
        end
    endgenerate

`ifdef SORT_STAT_EN
    // -----------------------------------------------------------------------
    // Swap statistics. A swap happened exactly when the comparator moved B
    // into the lower slot, which shows up as Min differing from A; this
    // needs only an equality test, not a second magnitude compare.
    // -----------------------------------------------------------------------
    logic [7:0] swap_cnt_reg;
    logic       swapped;

    assign swapped = sort_en && (min_val != a_val);

    always_ff @(posedge clk) begin
        if (rst) begin
            swap_cnt_reg <= '0;
        end else if (accept && (wr_idx_reg == LAST)) begin
            swap_cnt_reg <= '0;
        end else if (swapped) begin
            swap_cnt_reg <= swap_cnt_reg + 8'd1;
        end
    end

    assign swap_cnt = swap_cnt_reg;
`endif

endmodule

// File: tb/tb_sort_seq_8bit.sv
// ---------------------------------------------------------------------------
// tb_sort_seq_8bit
// Directed and random stimulus for sort_seq_8bit (N=4). Each loaded batch
// pushes its reference ascending order onto a queue; the drain phase pops
// and compares every output element. The swap count is checked against the
// inversion count of the batch when SORT_STAT_EN is defined.
// ---------------------------------------------------------------------------
module tb_sort_seq_8bit;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
`ifdef SORT_STAT_EN
    logic [7:0] swap_cnt;
`endif

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    int         exp_swaps   = 0;
    logic [7:0] batch [N];

    always #5 clk = ~clk;

    sort_seq_8bit #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef SORT_STAT_EN
        ,
        .swap_cnt  (swap_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample/drive point is 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feed one batch, pushing the reference result onto the scoreboard.
    // in_valid stays high with junk data afterwards to show it is ignored.
    task automatic load_batch(input logic [7:0] d [N]);
        logic [7:0] s [N];
        logic [7:0] t;
        int         inv;
        inv = 0;
        for (int i = 0; i < N; i++) s[i] = d[i];
        for (int i = 1; i < N; i++) begin
            for (int j = i; j > 0; j--) begin
                if (s[j-1] > s[j]) begin
                    t = s[j]; s[j] = s[j-1]; s[j-1] = t;
                end
            end
        end
        for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++)
                if (d[i] > d[j]) inv++;
        for (int i = 0; i < N; i++) exp_q.push_back(s[i]);
        exp_swaps = inv;
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_data  = d[i];
            check("in_ready_load", in_ready, 1);
            $display("load[%0d] data=%0d", i, d[i]);
            step();
        end
        in_data = 8'hAA;
    endtask

    // Wait for the sort to finish, checking latency and busy duration.
    task automatic wait_sort();
        int cyc;
        int busy_cyc;
        cyc      = 0;
        busy_cyc = 0;
        while (out_valid !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) busy_cyc++;
            check("in_ready_sort", in_ready, 0);
            check("out_data_idle", out_data, 0);
            step();
            cyc++;
        end
        check("sort_latency", cyc, (N-1)*(N-1));
        check("busy_cycles", busy_cyc, (N-1)*(N-1));
        check("busy_drain", busy, 0);
`ifdef SORT_STAT_EN
        check("swap_cnt_sorted", swap_cnt, exp_swaps);
`endif
    endtask

    // Pop and compare every queued element, optionally with random stalls.
    task automatic drain(input bit rnd);
        int guard;
        guard    = 0;
        in_valid = 1'b0;
        while (exp_q.size() > 0 && guard < 200) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            check("out_valid", out_valid, 1);
            check("out_data", out_data, exp_q[0]);
            check("in_ready_drain", in_ready, 0);
            step();
            guard++;
            if (out_ready) begin
                $display("out data=%0d expected=%0d", out_data, exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
        check("drain_done", exp_q.size(), 0);
        out_ready = 1'b0;
        check("out_valid_load", out_valid, 0);
        check("out_data_load", out_data, 0);
        check("in_ready_after", in_ready, 1);
`ifdef SORT_STAT_EN
        check("swap_cnt_hold", swap_cnt, exp_swaps);
`endif
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
`ifdef SORT_STAT_EN
        check("rst_swap_cnt", swap_cnt, 0);
`endif

        // Batch 1 with a 5-cycle output stall while in_valid stays high
        batch = '{8'd31, 8'd230, 8'd134, 8'd127};
        load_batch(batch);
        wait_sort();
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_out_data", out_data, 31);
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            step();
        end
        drain(1'b0);

        // Batch 2: duplicates, stable handling of equal values
        batch = '{8'd136, 8'd136, 8'd5, 8'd136};
        load_batch(batch);
        wait_sort();
        drain(1'b0);

        // Batch 3: fully reversed extremes
        batch = '{8'd255, 8'd128, 8'd1, 8'd0};
        load_batch(batch);
        wait_sort();
        drain(1'b0);

        // Reset during the 4th sort cycle abandons the batch
        batch = '{8'd20, 8'd10, 8'd30, 8'd5};
        load_batch(batch);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_out_data", out_data, 0);
`ifdef SORT_STAT_EN
        check("midrst_swap_cnt", swap_cnt, 0);
`endif
        batch = '{8'd9, 8'd8, 8'd7, 8'd6};
        load_batch(batch);
        wait_sort();
        drain(1'b0);

        // Random batches with random output back-pressure
        void'($urandom(314159));
        for (int b = 0; b < 7; b++) begin
            for (int i = 0; i < N; i++) begin
                if (b % 2 == 1) batch[i] = 8'($urandom_range(0, 7));
                else            batch[i] = 8'($urandom_range(0, 255));
            end
            load_batch(batch);
            wait_sort();
            drain(1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
